// File: rtl/sipo_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// sipo_word_assembler_pkg : shared encodings, defaults and helpers | Rev 1.0
// ============================================================================
package sipo_word_assembler_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Bits needed to count 0..v-1 (v >= 2).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_buf.sv
`default_nettype none
// ============================================================================
// sipo_out_buf : valid/ready holding register with sticky overrun | Rev 1.0
// ============================================================================
module sipo_out_buf
    import sipo_word_assembler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             dout_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    out_state_t state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_EMPTY;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (word_done) begin
                        dout  <= word;
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A word completing while the consumer drains loads with no bubble.
                    if (dout_ready) begin
                        if (word_done) dout  <= word;
                        else           state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase

            if (word_done && (state == ST_FULL) && !dout_ready)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

    assign dout_valid = (state == ST_FULL);

endmodule
`default_nettype wire

// File: rtl/sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// sipo_word_assembler : serial bit stream to WIDTH-bit words (top) | Rev 1.0
// ============================================================================
module sipo_word_assembler
    import sipo_word_assembler_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             din_sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] shift_next;
    logic             word_done;

    // A sync bit restarts the word, so it shifts into an empty register.
    assign shift_base = din_sync ? '0 : shreg;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_base[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign shift_next = {din, shift_base[WIDTH-1:1]};
        end
    endgenerate

    assign word_done = din_en && !din_sync && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (din_en) begin
            shreg <= shift_next;
            if (din_sync)
                bit_cnt <= CW'(1);
            else if (bit_cnt == LAST_BIT)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + CW'(1);
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .word       (shift_next),
        .word_done  (word_done),
        .dout_ready (dout_ready),
        .clr_ovr    (clr_ovr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

endmodule
`default_nettype wire

// File: tb/tb_sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// tb_sipo_word_assembler : scoreboard bench, MSB-first and LSB-first units | Rev 1.0
// ============================================================================
module tb_sipo_word_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic       din_sync = 1'b0;
    logic       dout_ready = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [7:0] dout_m, dout_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .din_sync(din_sync),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .overrun(ovr_m), .clr_ovr(clr_ovr)
    );

    sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .din_sync(din_sync),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .overrun(ovr_l), .clr_ovr(clr_ovr)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial order is w[7] first; the MSB-first unit yields w, the LSB-first unit rev8(w).
    task automatic expect_word(input logic [7:0] w);
        q_m.push_back(w);
        q_l.push_back(rev8(w));
    endtask

    task automatic send_bit(input logic b, input logic s);
        din      = b;
        din_sync = s;
        din_en   = 1'b1;
        @(posedge clk);
        #1;
        din_en   = 1'b0;
        din_sync = 1'b0;
        din      = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
    endtask

    // Monitors: a word is "presented" when valid rises or stays up right after a handshake.
    logic       pv_m = 1'b0, pt_m = 1'b0, pv_l = 1'b0, pt_l = 1'b0;
    logic [7:0] pd_m = '0, pd_l = '0;

    always @(negedge clk) begin
        if (valid_m && (!pv_m || pt_m)) begin
            if (q_m.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL msb_word: got %h, expected no word", dout_m);
            end else chk("msb_word", dout_m, q_m.pop_front());
        end else if (valid_m && pv_m && !pt_m) chk("msb_hold", dout_m, pd_m);
        pv_m = valid_m; pt_m = valid_m && dout_ready; pd_m = dout_m;
    end

    always @(negedge clk) begin
        if (valid_l && (!pv_l || pt_l)) begin
            if (q_l.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL lsb_word: got %h, expected no word", dout_l);
            end else chk("lsb_word", dout_l, q_l.pop_front());
        end else if (valid_l && pv_l && !pt_l) chk("lsb_hold", dout_l, pd_l);
        pv_l = valid_l; pt_l = valid_l && dout_ready; pd_l = dout_l;
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {valid_m, valid_l}, 2'b00);
        chk("rst_dout", {dout_m, dout_l}, 16'h0000);
        chk("rst_ovr", {ovr_m, ovr_l}, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {valid_m, valid_l}, 2'b00);

        // 1/2: A5 stream, valid only after the 8th bit; palindrome on LSB-first unit
        expect_word(8'hA5);
        send_range(8'hA5, 7, 1);
        @(negedge clk);
        chk("a5_not_yet_valid", {valid_m, valid_l}, 2'b00);
        send_range(8'hA5, 0, 0);
        @(negedge clk);
        chk("a5_valid", {valid_m, valid_l}, 2'b11);
        chk("a5_dout_msb", dout_m, 8'hA5);
        chk("a5_dout_lsb", dout_l, 8'hA5);
        chk("a5_ovr", {ovr_m, ovr_l}, 2'b00);
        drain();
        @(negedge clk);
        chk("drained_valid", {valid_m, valid_l}, 2'b00);
        chk("drained_dout_kept", dout_m, 8'hA5);

        expect_word(8'h80);
        send_range(8'h80, 7, 0);
        @(negedge clk);
        chk("one_lsb", dout_l, 8'h01);
        chk("one_msb", dout_m, 8'h80);
        drain();

        // 3: back-to-back 3C then C3, handshake on the completion edge
        expect_word(8'h3C);
        send_range(8'h3C, 7, 0);
        expect_word(8'hC3);
        send_range(8'hC3, 7, 1);
        @(negedge clk);
        chk("b2b_before_valid", {valid_m, valid_l}, 2'b11);
        chk("b2b_before_dout", dout_m, 8'h3C);
        dout_ready = 1'b1;
        send_range(8'hC3, 0, 0);
        dout_ready = 1'b0;
        @(negedge clk);
        chk("b2b_after_valid", {valid_m, valid_l}, 2'b11);
        chk("b2b_after_dout", dout_m, 8'hC3);
        chk("b2b_ovr", {ovr_m, ovr_l}, 2'b00);
        drain();

        // 4: overrun, clear, and set-over-clear priority
        expect_word(8'h11);
        send_range(8'h11, 7, 0);
        send_range(8'h22, 7, 0);
        @(negedge clk);
        chk("ovr_dout_msb", dout_m, 8'h11);
        chk("ovr_dout_lsb", dout_l, 8'h88);
        chk("ovr_set", {ovr_m, ovr_l}, 2'b11);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", {ovr_m, ovr_l}, 2'b00);
        send_range(8'h33, 7, 1);
        clr_ovr = 1'b1;
        send_range(8'h33, 0, 0);
        clr_ovr = 1'b0;
        @(negedge clk);
        chk("ovr_set_beats_clr", {ovr_m, ovr_l}, 2'b11);
        chk("ovr_dout_still", dout_m, 8'h11);
        clr_ovr = 1'b1;
        drain();
        clr_ovr = 1'b0;

        // 5: resync after 3 partial bits
        send_range(8'hE0, 7, 5);
        expect_word(8'h80);
        send_bit(1'b1, 1'b1);
        send_range(8'h00, 6, 0);
        @(negedge clk);
        chk("sync_msb", dout_m, 8'h80);
        chk("sync_lsb", dout_l, 8'h01);
        chk("sync_ovr", {ovr_m, ovr_l}, 2'b00);

        // 6: asynchronous reset mid-word with a pending word and overrun set
        send_range(8'hFF, 7, 0);
        @(negedge clk);
        chk("pre_rst_ovr", {ovr_m, ovr_l}, 2'b11);
        send_range(8'hFF, 7, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {valid_m, valid_l}, 2'b00);
        chk("async_rst_dout", {dout_m, dout_l}, 16'h0000);
        chk("async_rst_ovr", {ovr_m, ovr_l}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        expect_word(8'h5B);
        send_range(8'h5B, 7, 0);
        @(negedge clk);
        chk("fresh_msb", dout_m, 8'h5B);
        chk("fresh_lsb", dout_l, 8'hDA);
        drain();

        repeat (2) @(negedge clk);
        chk("scoreboard_empty_msb", q_m.size(), 0);
        chk("scoreboard_empty_lsb", q_l.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
